// File: rtl/vending_machine_change.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_change
// Purpose  : Multi-product vending controller with credit in 5-rupee units,
//            per-product prices, cancel/refund and serial change pulses.
// Revision : 1.0 - initial release
// ============================================================================
module vending_machine_change #(
    parameter int NUM_PRODUCTS = 4,
    parameter int CREDIT_W     = 6,
    parameter int MAX_CREDIT   = 20,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {6'd6, 6'd4, 6'd3, 6'd2}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              coin,
    input  logic [NUM_PRODUCTS-1:0] select,
    input  logic                    cancel,
    output logic [NUM_PRODUCTS-1:0] product,
    output logic                    change,
    output logic                    coin_reject,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    busy
);

    localparam logic [1:0] ACCUM  = 2'd0;
    localparam logic [1:0] VEND   = 2'd1;
    localparam logic [1:0] CHANGE = 2'd2;

    localparam logic [CREDIT_W-1:0] ONE_UNIT    = CREDIT_W'(1);
    localparam logic [CREDIT_W:0]   CREDIT_CEIL = (CREDIT_W+1)'(MAX_CREDIT);

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] w_coin_value;
    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_present;
    logic                w_coin_fits;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_can_vend;

    always_comb begin
        case (coin)
            2'b01:   w_coin_value = CREDIT_W'(1);
            2'b10:   w_coin_value = CREDIT_W'(2);
            2'b11:   w_coin_value = CREDIT_W'(4);
            default: w_coin_value = '0;
        endcase
    end

    // Sum is one bit wider so the ceiling test sees a would-be overflow.
    assign w_coin_present = (coin != 2'b00);
    assign w_coin_sum     = {1'b0, credit} + {1'b0, w_coin_value};
    assign w_coin_fits    = (w_coin_sum <= CREDIT_CEIL);

    always_comb begin
        w_sel_price = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (select[i]) begin
                w_sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign w_can_vend = $onehot(select) && (credit >= w_sel_price);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ACCUM;
            credit      <= '0;
            product     <= '0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            product     <= '0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (cancel) begin
                        coin_reject <= w_coin_present;
                        if (credit != '0) begin
                            r_state <= CHANGE;
                            busy    <= 1'b1;
                            change  <= 1'b1;
                            credit  <= credit - ONE_UNIT;
                        end
                    end else if (w_can_vend) begin
                        coin_reject <= w_coin_present;
                        r_state     <= VEND;
                        busy        <= 1'b1;
                        product     <= select;
                        credit      <= credit - w_sel_price;
                    end else if (w_coin_present) begin
                        if (w_coin_fits) begin
                            credit <= w_coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                VEND, CHANGE: begin
                    // The first change pulse leaves VEND directly, so VEND and
                    // CHANGE share the same pay-out step.
                    coin_reject <= w_coin_present;
                    if (credit != '0) begin
                        r_state <= CHANGE;
                        change  <= 1'b1;
                        credit  <= credit - ONE_UNIT;
                    end else begin
                        r_state <= ACCUM;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_change.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_machine_change
// Purpose  : Directed self-checking bench with a schedule-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_machine_change;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin = 2'b00;
    logic [3:0] select = 4'b0000;
    logic       cancel = 1'b0;
    logic [3:0] product;
    logic       change;
    logic       coin_reject;
    logic [5:0] credit;
    logic       busy;

    int checks = 0;
    int errors = 0;

    vending_machine_change dut (
        .clk         (clk),
        .reset       (reset),
        .coin        (coin),
        .select      (select),
        .cancel      (cancel),
        .product     (product),
        .change      (change),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: an accepted vend or cancel becomes a list of future
    // per-cycle outputs; the machine is busy while that list is being played.
    typedef struct {
        logic [3:0] prod;
        logic       chg;
        int         cr;
    } ev_t;

    ev_t        q[$];
    ev_t        m_ev;
    int         m_credit = 0;
    int         m_val;
    int         m_price;
    int         m_k;
    logic       m_rej;
    int         price_tab[4] = '{2, 3, 4, 6};
    logic [3:0] exp_product = 4'b0;
    logic       exp_change = 1'b0;
    logic       exp_reject = 1'b0;
    int         exp_credit = 0;
    logic       exp_busy = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_credit    = 0;
            exp_product = 4'b0;
            exp_change  = 1'b0;
            exp_reject  = 1'b0;
            exp_credit  = 0;
            exp_busy    = 1'b0;
        end else begin
            m_rej = 1'b0;
            m_val = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : (coin == 2'b11) ? 4 : 0;
            m_price = 0;
            for (int i = 0; i < 4; i++) if (select[i]) m_price = price_tab[i];
            if (exp_busy) begin
                m_rej = (coin != 2'b00);
            end else if (cancel) begin
                m_rej = (coin != 2'b00);
                for (int j = 1; j <= m_credit; j++) begin
                    m_ev.prod = 4'b0; m_ev.chg = 1'b1; m_ev.cr = m_credit - j;
                    q.push_back(m_ev);
                end
                m_credit = 0;
            end else if ($countones(select) == 1 && m_credit >= m_price) begin
                m_rej = (coin != 2'b00);
                m_k = m_credit - m_price;
                m_ev.prod = select; m_ev.chg = 1'b0; m_ev.cr = m_k;
                q.push_back(m_ev);
                for (int j = 1; j <= m_k; j++) begin
                    m_ev.prod = 4'b0; m_ev.chg = 1'b1; m_ev.cr = m_k - j;
                    q.push_back(m_ev);
                end
                m_credit = 0;
            end else if (m_val > 0) begin
                if (m_credit + m_val <= 20) m_credit = m_credit + m_val;
                else m_rej = 1'b1;
            end
            exp_reject = m_rej;
            if (q.size() > 0) begin
                m_ev = q.pop_front();
                exp_product = m_ev.prod;
                exp_change  = m_ev.chg;
                exp_credit  = m_ev.cr;
                exp_busy    = 1'b1;
            end else begin
                exp_product = 4'b0;
                exp_change  = 1'b0;
                exp_credit  = m_credit;
                exp_busy    = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_product", product, exp_product);
        chk("model_change", change, exp_change);
        chk("model_reject", coin_reject, exp_reject);
        chk("model_credit", credit, exp_credit);
        chk("model_busy", busy, exp_busy);
    end

    // Drive one cycle of inputs; returns just after the sampling edge.
    task automatic step(input logic [1:0] c, input logic [3:0] s, input logic x);
        @(negedge clk);
        coin = c; select = s; cancel = x;
        @(posedge clk);
        #2;
        coin = 2'b00; select = 4'b0000; cancel = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_credit", credit, 0);
        chk("reset_busy", busy, 0);
        chk("reset_product", product, 0);
        @(negedge clk);
        reset = 1'b1;

        // 5 then 10, then product 1 at exact price
        step(2'b01, 4'b0000, 1'b0); chk("t1_credit_a", credit, 1);
        step(2'b10, 4'b0000, 1'b0); chk("t1_credit_b", credit, 3);
        step(2'b00, 4'b0010, 1'b0); chk("t1_product", product, 4'b0010);
        chk("t1_busy", busy, 1); chk("t1_credit_c", credit, 0);
        step(2'b00, 4'b0000, 1'b0); chk("t1_idle_busy", busy, 0); chk("t1_no_change", change, 0);

        // 20 then product 0: two change pulses
        step(2'b11, 4'b0000, 1'b0); chk("t2_credit", credit, 4);
        step(2'b00, 4'b0001, 1'b0); chk("t2_product", product, 4'b0001); chk("t2_credit_b", credit, 2);
        step(2'b00, 4'b0000, 1'b0); chk("t2_change_a", change, 1);
        step(2'b00, 4'b0000, 1'b0); chk("t2_change_b", change, 1); chk("t2_credit_c", credit, 0);
        step(2'b00, 4'b0000, 1'b0); chk("t2_busy_end", busy, 0); chk("t2_change_end", change, 0);

        // insufficient credit and multi-hot selects are ignored
        step(2'b01, 4'b0000, 1'b0);
        step(2'b00, 4'b1000, 1'b0); chk("t3_no_product", product, 0); chk("t3_credit", credit, 1);
        step(2'b10, 4'b0000, 1'b0);
        step(2'b01, 4'b0000, 1'b0); chk("t3_credit_b", credit, 4);
        step(2'b00, 4'b0011, 1'b0); chk("t3_multihot", product, 0); chk("t3_busy", busy, 0);
        step(2'b00, 4'b0000, 1'b1);
        repeat (5) step(2'b00, 4'b0000, 1'b0);

        // cancel with a coin in the same cycle
        step(2'b10, 4'b0000, 1'b0);
        step(2'b01, 4'b0000, 1'b0); chk("t4_credit", credit, 3);
        step(2'b11, 4'b0000, 1'b1); chk("t4_reject", coin_reject, 1); chk("t4_change", change, 1);
        repeat (3) step(2'b00, 4'b0000, 1'b0);
        chk("t4_credit_end", credit, 0); chk("t4_busy_end", busy, 0);

        // saturation, then coins during VEND/CHANGE
        repeat (5) step(2'b11, 4'b0000, 1'b0);
        chk("t5_credit_full", credit, 20);
        step(2'b01, 4'b0000, 1'b0); chk("t5_reject", coin_reject, 1); chk("t5_credit_held", credit, 20);
        step(2'b00, 4'b1000, 1'b0); chk("t5_product", product, 4'b1000); chk("t5_credit_b", credit, 14);
        for (int i = 0; i < 15; i++) begin
            step(2'b01, 4'b0000, 1'b0);
            chk("t5_busy_reject", coin_reject, 1);
        end
        chk("t5_credit_end", credit, 0);
        step(2'b00, 4'b0000, 1'b0); chk("t5_idle", busy, 0);

        // asynchronous reset during the first change pulse
        step(2'b11, 4'b0000, 1'b0);
        step(2'b00, 4'b0001, 1'b0);
        step(2'b00, 4'b0000, 1'b0); chk("t6_change_before", change, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_change_rst", change, 0); chk("t6_credit_rst", credit, 0);
        chk("t6_busy_rst", busy, 0); chk("t6_product_rst", product, 0);
        chk("t6_reject_rst", coin_reject, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(2'b01, 4'b0000, 1'b0); chk("t6_after_release", credit, 1);
        repeat (2) step(2'b00, 4'b0000, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
